// File: rtl/load_store_unit_if.sv
// Execute-to-writeback bus of the load/store stage: upstream handshake, data-memory port
// and registered result. The LSU takes the slave side; its environment takes the master side.
interface load_store_unit_if #(
  parameter int AW  = 4,
  parameter int DW  = 8,
  parameter int RW_ = 3
);
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_op;
  logic [AW-1:0]  in_addr;
  logic [DW-1:0]  in_data;
  logic [RW_-1:0] in_rd;

  logic           mem_rw;
  logic [AW-1:0]  mem_address;
  logic [DW-1:0]  mem_data_in;
  logic [DW-1:0]  mem_data_out;

  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [RW_-1:0] out_rd;
  logic           out_we;

  modport slave (
    input  in_valid, in_op, in_addr, in_data, in_rd, mem_data_out, out_ready,
    output in_ready, mem_rw, mem_address, mem_data_in, out_valid, out_data, out_rd, out_we
  );

  modport master (
    output in_valid, in_op, in_addr, in_data, in_rd, mem_data_out, out_ready,
    input  in_ready, mem_rw, mem_address, mem_data_in, out_valid, out_data, out_rd, out_we
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: ALU pass-through, one-cycle store, or registered-memory load, one
// transaction in flight. Define LSU_PERF_CNT_EN to add the ld_count/st_count counters.
module load_store_unit #(
  parameter int AW  = 4,
  parameter int DW  = 8,
  parameter int RW_ = 3
) (
  input  logic                clk,
  input  logic                clr_n,
  load_store_unit_if.slave    bus
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [15:0]         ld_count,
  output logic [15:0]         st_count
`endif
);

  typedef enum logic [1:0] {OP_PASS = 2'b00, OP_LOAD = 2'b01, OP_STORE = 2'b10, OP_NOP = 2'b11} op_t;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t         state, state_nxt;
  op_t            in_op;
  op_t            req_op;
  logic [RW_-1:0] req_rd;
  logic [AW-1:0]  mem_addr_q;
  logic [DW-1:0]  mem_wdata_q;

  logic           out_valid_q, out_we_q;
  logic [DW-1:0]  out_data_q;
  logic [RW_-1:0] out_rd_q;

  logic           in_ready_c, accept, mem_rw_c, issue_store, issue_load;
  logic           out_load, out_we_nxt;
  logic [DW-1:0]  out_data_nxt;
  logic [RW_-1:0] out_rd_nxt;

  assign in_op  = op_t'(bus.in_op);
  assign accept = bus.in_valid && in_ready_c;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: defaults first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (in_op == OP_LOAD || in_op == OP_STORE)) state_nxt = ISSUE;
      ISSUE:   state_nxt = (req_op == OP_LOAD) ? CAPTURE : IDLE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c   = clr_n && (state == IDLE) && (!out_valid_q || bus.out_ready);
    issue_store  = (state == ISSUE) && (req_op == OP_STORE);
    issue_load   = (state == ISSUE) && (req_op == OP_LOAD);
    mem_rw_c     = clr_n && issue_store;
    out_load     = 1'b0;
    out_data_nxt = out_data_q;
    out_rd_nxt   = out_rd_q;
    out_we_nxt   = out_we_q;
    case (state)
      IDLE: begin
        if (accept && in_op == OP_PASS) begin
          out_load     = 1'b1;
          out_data_nxt = bus.in_data;
          out_rd_nxt   = bus.in_rd;
          out_we_nxt   = 1'b1;
        end else if (accept && in_op == OP_NOP) begin
          out_load     = 1'b1;
          out_data_nxt = '0;
          out_rd_nxt   = bus.in_rd;
          out_we_nxt   = 1'b0;
        end
      end
      ISSUE: begin
        if (issue_store) begin
          out_load     = 1'b1;
          out_data_nxt = mem_wdata_q;
          out_rd_nxt   = req_rd;
          out_we_nxt   = 1'b0;
        end
      end
      CAPTURE: begin
        out_load     = 1'b1;
        out_data_nxt = bus.mem_data_out;
        out_rd_nxt   = req_rd;
        out_we_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  // Memory address/data only move when a memory op is accepted, so they hold between accesses.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      req_op      <= OP_NOP;
      req_rd      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      out_we_q    <= 1'b0;
    end else begin
      if (accept) begin
        req_op <= in_op;
        req_rd <= bus.in_rd;
        if (in_op == OP_LOAD || in_op == OP_STORE) mem_addr_q  <= bus.in_addr;
        if (in_op == OP_STORE)                     mem_wdata_q <= bus.in_data;
      end
      if (out_load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= out_data_nxt;
        out_rd_q    <= out_rd_nxt;
        out_we_q    <= out_we_nxt;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      ld_count <= '0;
      st_count <= '0;
    end else begin
      if (issue_load)  ld_count <= ld_count + 16'd1;
      if (issue_store) st_count <= st_count + 16'd1;
    end
  end
`endif

  assign bus.in_ready    = in_ready_c;
  assign bus.mem_rw      = mem_rw_c;
  assign bus.mem_address = mem_addr_q;
  assign bus.mem_data_in = mem_wdata_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_we      = out_we_q;

endmodule
